// File: rtl/nios_lcell_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nios_lcell_timer_ctrl_if
// Purpose  : Avalon-MM slave bus bundle for the LCELL interval timer
//            controller (zero-wait-state register access).
// Signals  : chipselect  - slave select
//            address[1:0]- register index
//            write       - write strobe (qualified by chipselect)
//            writedata   - write data, CNT_W bits
//            readdata    - read data, CNT_W bits, combinational from address
// Modports : master (bus host side), slave (timer side)
// Revision : 1.0 - initial release
// ============================================================================
interface nios_lcell_timer_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             chipselect;
  logic [1:0]       address;
  logic             write;
  logic [CNT_W-1:0] writedata;
  logic [CNT_W-1:0] readdata;

  modport master (
    output chipselect,
    output address,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  chipselect,
    input  address,
    input  write,
    input  writedata,
    output readdata
  );
endinterface
`default_nettype wire

// File: rtl/nios_lcell_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nios_lcell_timer_ctrl
// Purpose  : Avalon-slave controller sequencing an external counter-mode LCELL
//            chain as a Nios interval timer. Owns the prescaler, the period
//            down-counter and the IDLE/LOAD/RUN state machine, and raises a
//            level IRQ on timeout.
// Ports    : clk        - system clock, rising edge
//            reset      - synchronous, active-high
//            avs        - Avalon slave bus (nios_lcell_timer_ctrl_if.slave)
//            irq        - level interrupt, TO & ITO
//            chain_ena  - 1-clk enable per prescaled tick while running
//            chain_clr  - 1-clk synchronous clear to the chain on (re)start
//            running    - high in LOAD or RUN
// Registers: 0 STATUS   rd {RUN,TO}; any write clears TO
//            1 CONTROL  bit0 ITO, bit1 CONT; bit2 START, bit3 STOP strobes
//            2 PERIOD   rd/wr
//            3 PRESCALE rd/wr (low PRE_W bits)
// Option   : NIOS_LCELL_TMR_SNAPSHOT_EN - a write to STATUS also captures the
//            live count; address 3 then reads the snapshot and PRESCALE
//            becomes write-only.
// Revision : 1.0 - initial release
// ============================================================================
module nios_lcell_timer_ctrl #(
  parameter int CNT_W = 16,
  parameter int PRE_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  nios_lcell_timer_ctrl_if.slave  avs,
  output logic                    irq,
  output logic                    chain_ena,
  output logic                    chain_clr,
  output logic                    running
);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_load = 2'd1;
  localparam logic [1:0] c_st_run  = 2'd2;

  logic [1:0]       r_state;
  logic             r_to;
  logic             r_ito;
  logic             r_cont;
  logic [CNT_W-1:0] r_period;
  logic [PRE_W-1:0] r_prescale;
  logic [CNT_W-1:0] r_count;
  logic [PRE_W-1:0] r_pre_cnt;
`ifdef NIOS_LCELL_TMR_SNAPSHOT_EN
  logic [CNT_W-1:0] r_snap;
`endif

  logic w_wr;
  logic w_wr_status;
  logic w_wr_ctrl;
  logic w_start;
  logic w_stop;
  logic w_tick;
  logic w_expire;
  logic w_running;

  assign w_wr        = avs.chipselect & avs.write;
  assign w_wr_status = w_wr & (avs.address == 2'd0);
  assign w_wr_ctrl   = w_wr & (avs.address == 2'd1);
  assign w_start     = w_wr_ctrl & avs.writedata[2];
  assign w_stop      = w_wr_ctrl & avs.writedata[3];

  // A START or STOP strobe in RUN pre-empts the tick: the counters are held
  // (STOP) or about to be reloaded (START), so no chain enable is issued.
  assign w_tick    = (r_state == c_st_run) && (r_pre_cnt == '0) && !w_start && !w_stop;
  assign w_expire  = w_tick && (r_count == '0);
  assign w_running = (r_state != c_st_idle);

  assign chain_ena = w_tick;
  assign chain_clr = (r_state == c_st_load);
  assign running   = w_running;
  assign irq       = r_to & r_ito;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_st_idle;
      r_to       <= 1'b0;
      r_ito      <= 1'b0;
      r_cont     <= 1'b0;
      r_period   <= '1;
      r_prescale <= '0;
      r_count    <= '0;
      r_pre_cnt  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_ito  <= avs.writedata[0];
        r_cont <= avs.writedata[1];
      end
      if (w_wr && (avs.address == 2'd2)) begin
        r_period <= avs.writedata;
      end
      if (w_wr && (avs.address == 2'd3)) begin
        r_prescale <= avs.writedata[PRE_W-1:0];
      end

      // Setting TO takes priority over a simultaneous STATUS-write clear so a
      // timeout can never be lost.
      if (w_expire) begin
        r_to <= 1'b1;
      end else if (w_wr_status) begin
        r_to <= 1'b0;
      end

      case (r_state)
        c_st_idle: begin
          if (w_start) begin
            r_state <= c_st_load;
          end
        end
        c_st_load: begin
          r_count   <= r_period;
          r_pre_cnt <= r_prescale;
          if (w_start) begin
            r_state <= c_st_load;
          end else if (w_stop) begin
            r_state <= c_st_idle;
          end else begin
            r_state <= c_st_run;
          end
        end
        c_st_run: begin
          if (w_start) begin
            r_state <= c_st_load;
          end else if (w_stop) begin
            r_state <= c_st_idle;
          end else if (r_pre_cnt != '0) begin
            r_pre_cnt <= r_pre_cnt - PRE_W'(1);
          end else begin
            r_pre_cnt <= r_prescale;
            if (r_count != '0) begin
              r_count <= r_count - CNT_W'(1);
            end else if (r_cont) begin
              r_count <= r_period;
            end else begin
              r_state <= c_st_idle;
            end
          end
        end
        default: begin
          r_state <= c_st_idle;
        end
      endcase
    end
  end

`ifdef NIOS_LCELL_TMR_SNAPSHOT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap <= '0;
    end else if (w_wr_status) begin
      r_snap <= r_count;
    end
  end
`endif

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      2'd0: avs.readdata = {{(CNT_W-2){1'b0}}, w_running, r_to};
      2'd1: avs.readdata = {{(CNT_W-2){1'b0}}, r_cont, r_ito};
      2'd2: avs.readdata = r_period;
`ifdef NIOS_LCELL_TMR_SNAPSHOT_EN
      2'd3: avs.readdata = r_snap;
`else
      2'd3: avs.readdata = {{(CNT_W-PRE_W){1'b0}}, r_prescale};
`endif
      default: avs.readdata = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_nios_lcell_timer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nios_lcell_timer_ctrl
// Purpose  : Self-checking bench for nios_lcell_timer_ctrl. Expected values
//            come from the timing rules expressed as arithmetic on the number
//            of clocks elapsed since LOAD.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nios_lcell_timer_ctrl;

  logic clk;
  logic reset;
  logic irq;
  logic chain_ena;
  logic chain_clr;
  logic running;

  int total;
  int bad;
  int pre;
  int per;
  int cont;
  int tmo;
  int lim;
  logic exp_to;
  logic wrk;

  nios_lcell_timer_ctrl_if #(.CNT_W(16)) bus ();

  nios_lcell_timer_ctrl #(.CNT_W(16), .PRE_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .avs       (bus),
    .irq       (irq),
    .chain_ena (chain_ena),
    .chain_clr (chain_clr),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] a, input logic [15:0] d);
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    bus.address    = a;
    bus.writedata  = d;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    drive_wr(a, d);
    step();
    bus_idle();
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [15:0] exp);
    bus.address = a;
    #1;
    chk(tag, {16'h0, bus.readdata}, {16'h0, exp});
  endtask

  initial begin
    total = 0;
    bad   = 0;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
    bus.address    = 2'd0;
    bus.writedata  = 16'h0;
    reset = 1'b1;

    // reset held for two clocks
    step();
    step();
    chk("rst_irq", irq, 1'b0);
    chk("rst_ena", chain_ena, 1'b0);
    chk("rst_clr", chain_clr, 1'b0);
    chk("rst_running", running, 1'b0);
    reset = 1'b0;
    rd_chk("rst_status", 2'd0, 16'h0000);
    rd_chk("rst_control", 2'd1, 16'h0000);
    rd_chk("rst_period", 2'd2, 16'hFFFF);
    step();

    // one-shot: PRESCALE=0, PERIOD=3, ITO|START
    wr(2'd3, 16'd0);
    rd_chk("presc_rd", 2'd3, 16'h0000);
    wr(2'd2, 16'd3);
    rd_chk("period_rd", 2'd2, 16'd3);
    wr(2'd1, 16'h5);
    chk("os_clr_load", chain_clr, 1'b1);
    chk("os_running_load", running, 1'b1);
    chk("os_ena_load", chain_ena, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("os_ena", chain_ena, 1'b1);
      chk("os_clr", chain_clr, 1'b0);
      chk("os_irq_pre", irq, 1'b0);
    end
    step();
    chk("os_irq", irq, 1'b1);
    chk("os_running_end", running, 1'b0);
    chk("os_ena_end", chain_ena, 1'b0);
    rd_chk("os_status", 2'd0, 16'h0001);
    wr(2'd0, 16'h0);
    chk("os_irq_clr", irq, 1'b0);

    // continuous: PRESCALE=2, PERIOD=1; status writes at k=8 (clear) and k=12 (collides with set)
    wr(2'd3, 16'd2);
    wr(2'd2, 16'd1);
    wr(2'd1, 16'h7);
    exp_to = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      bus_idle();
      chk("ct_ena", chain_ena, (k % 3) == 0);
      chk("ct_irq", irq, exp_to);
      chk("ct_running", running, 1'b1);
      wrk = (k == 8) || (k == 12);
      if (wrk) drive_wr(2'd0, 16'h0);
      if ((k % 6) == 0) exp_to = 1'b1;
      else if (wrk) exp_to = 1'b0;
    end
    step();
    bus_idle();
    chk("ct_irq_final", irq, exp_to);
    wr(2'd1, 16'h8);
    chk("ct_stopped", running, 1'b0);
    wr(2'd0, 16'h0);

    // STOP at count=5
    wr(2'd3, 16'd0);
    wr(2'd2, 16'd9);
    wr(2'd1, 16'h4);
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("stp_ena_run", chain_ena, 1'b1);
    end
    drive_wr(2'd1, 16'h8);
    #1;
    chk("stp_ena_suppressed", chain_ena, 1'b0);
    step();
    bus_idle();
    chk("stp_running", running, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stp_ena_after", chain_ena, 1'b0);
    end
`ifdef NIOS_LCELL_TMR_SNAPSHOT_EN
    wr(2'd0, 16'h0);
    rd_chk("stp_snap_held", 2'd3, 16'd5);
`endif

    // START|STOP while running restarts; PERIOD write mid-run applies next load only
    wr(2'd0, 16'h0);
    wr(2'd2, 16'd9);
    wr(2'd1, 16'h5);
    step();
    step();
    step();
    drive_wr(2'd1, 16'hD);
    #1;
    chk("rs_ena_strobe", chain_ena, 1'b0);
    step();
    bus_idle();
    chk("rs_clr", chain_clr, 1'b1);
    chk("rs_running", running, 1'b1);
    for (int k = 1; k <= 11; k++) begin
      step();
      bus_idle();
      chk("rs_ena", chain_ena, k <= 10);
      chk("rs_irq", irq, k == 11);
      if (k == 2) drive_wr(2'd2, 16'd2);
    end
    wr(2'd0, 16'h0);
    wr(2'd1, 16'h5);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("rs_newper_irq", irq, k == 4);
    end
    wr(2'd0, 16'h0);

    // randomized runs against the elapsed-clock model
    for (int it = 0; it < 8; it++) begin
      pre  = $urandom_range(0, 3);
      per  = $urandom_range(0, 4);
      cont = $urandom_range(0, 1);
      tmo  = (per + 1) * (pre + 1);
      lim  = (cont != 0) ? (2 * tmo + 3) : (tmo + 3);
      wr(2'd0, 16'h0);
      wr(2'd3, 16'(pre));
      wr(2'd2, 16'(per));
      wr(2'd1, 16'h5 | (16'(cont) << 1));
      for (int k = 0; k <= lim; k++) begin
        if (k > 0) step();
        chk("rnd_clr", chain_clr, k == 0);
        chk("rnd_running", running, (cont != 0) || (k <= tmo));
        chk("rnd_ena", chain_ena, (k >= 1) && ((k % (pre + 1)) == 0) && ((cont != 0) || (k <= tmo)));
        chk("rnd_irq", irq, k > tmo);
      end
      wr(2'd1, 16'h8);
      chk("rnd_stopped", running, 1'b0);
    end
    wr(2'd0, 16'h0);

`ifdef NIOS_LCELL_TMR_SNAPSHOT_EN
    // snapshot of a live count
    wr(2'd3, 16'd0);
    wr(2'd2, 16'h20);
    wr(2'd1, 16'h4);
    for (int k = 1; k <= 15; k++) step();
    wr(2'd0, 16'h0);
    rd_chk("snap_val", 2'd3, 16'h12);
    chk("snap_running", running, 1'b1);
    wr(2'd1, 16'h8);
`endif

    // reset mid-run clears TO and stops the chain
    wr(2'd3, 16'd0);
    wr(2'd2, 16'd0);
    wr(2'd1, 16'h7);
    step();
    step();
    step();
    chk("mr_irq_before", irq, 1'b1);
    reset = 1'b1;
    step();
    chk("mr_running", running, 1'b0);
    chk("mr_ena", chain_ena, 1'b0);
    chk("mr_clr", chain_clr, 1'b0);
    chk("mr_irq", irq, 1'b0);
    reset = 1'b0;
    rd_chk("mr_status", 2'd0, 16'h0000);
    rd_chk("mr_period", 2'd2, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
